// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state encoding and default parameters for the elevator controller
package elevator_pkg;

   // Car operating states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_e;

   // Default build parameters
   localparam int DEF_NUM_FLOORS  = 8;
   localparam int DEF_MOVE_CYCLES = 2;
   localparam int DEF_DOOR_CYCLES = 4;
   localparam int DEF_IDLE_CYCLES = 16;

endpackage

// File: rtl/elevator_req_reg.sv
// rtl/elevator_req_reg.sv - pending-call bitmap with set, door-hold mask and arrival clear
module elevator_req_reg
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS,
   localparam int FW = $clog2(NUM_FLOORS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] req,
   input  logic                  home_set,
   input  logic                  door_hold,
   input  logic [FW-1:0]         hold_floor,
   input  logic                  clr_en,
   input  logic [FW-1:0]         clr_floor,
   output logic [NUM_FLOORS-1:0] pending
);

   logic [NUM_FLOORS-1:0] pending_q;
   logic [NUM_FLOORS-1:0] pending_d;
   logic [NUM_FLOORS-1:0] set_mask;
   logic [NUM_FLOORS-1:0] hold_mask;
   logic [NUM_FLOORS-1:0] clr_mask;

   // Next bitmap: new calls are added, a call at an open door is dropped,
   // and the floor the car is arriving at is cleared (clear beats a same-cycle set)
   always_comb begin
      set_mask  = req;
      hold_mask = '0;
      clr_mask  = '0;
      if (home_set) begin
         set_mask[0] = 1'b1;
      end
      if (door_hold) begin
         hold_mask[hold_floor] = 1'b1;
      end
      if (clr_en) begin
         clr_mask[clr_floor] = 1'b1;
      end
      pending_d = (pending_q | (set_mask & ~hold_mask)) & ~clr_mask;
   end

   // Bitmap register
   always_ff @(posedge clock) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - single-car elevator FSM and timers; ELEVATOR_IDLE_HOME_EN adds return-to-floor-0
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
   parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
   parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
   parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
   localparam int FW = $clog2(NUM_FLOORS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stop,
   input  logic [NUM_FLOORS-1:0] req,
   output logic [FW-1:0]         floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  dir_up,
   output logic                  moving,
   output logic                  door_open,
   output logic                  arrived
);

   localparam int MCW = $clog2(MOVE_CYCLES) + 1;
   localparam int DCW = $clog2(DOOR_CYCLES) + 1;
   localparam logic [MCW-1:0] MC_LAST   = MCW'(MOVE_CYCLES - 1);
   localparam logic [DCW-1:0] DC_LAST   = DCW'(DOOR_CYCLES - 1);
   localparam logic [FW-1:0]  TOP_FLOOR = FW'(NUM_FLOORS - 1);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_MOVE = ST_MOVE;
   localparam logic [1:0] S_DOOR = ST_DOOR;

   logic [1:0]            state_q, state_d;
   logic [FW-1:0]         floor_q, floor_d;
   logic                  dir_up_q, dir_up_d;
   logic [MCW-1:0]        move_cnt_q, move_cnt_d;
   logic [DCW-1:0]        door_cnt_q, door_cnt_d;
   logic                  arrived_q, arrived_d;
   logic [NUM_FLOORS-1:0] pend_eff;
   logic [FW-1:0]         step_floor;
   logic                  go_above;
   logic                  go_below;
   logic                  home_set;

   // True when any bit of p lies strictly above (up=1) or below (up=0) floor f
   function automatic logic any_ahead(input logic [NUM_FLOORS-1:0] p,
                                      input logic [FW-1:0] f,
                                      input logic up);
      any_ahead = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) begin
            any_ahead = 1'b1;
         end
      end
   endfunction

   // Pending calls live in their own register block
   elevator_req_reg #(
      .NUM_FLOORS(NUM_FLOORS)
   ) u_req_reg (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .home_set  (home_set),
      .door_hold (state_q == S_DOOR),
      .hold_floor(floor_q),
      .clr_en    (arrived_d),
      .clr_floor (floor_d),
      .pending   (pending)
   );

   // Next-state logic: dispatch from IDLE, step and re-plan in MOVE, time the door in DOOR
   always_comb begin
      state_d    = state_q;
      floor_d    = floor_q;
      dir_up_d   = dir_up_q;
      move_cnt_d = move_cnt_q;
      door_cnt_d = door_cnt_q;
      step_floor = floor_q;
      pend_eff   = pending | req;
      go_above   = any_ahead(pend_eff, floor_q, 1'b1);
      go_below   = any_ahead(pend_eff, floor_q, 1'b0);

      case (state_q)
         S_IDLE: begin
            if (!stop) begin
               if (pend_eff[floor_q]) begin
                  state_d    = S_DOOR;
                  door_cnt_d = '0;
               end else if (go_above || go_below) begin
                  state_d    = S_MOVE;
                  move_cnt_d = '0;
                  // Calls on both sides keep the current heading
                  if (!(go_above && go_below)) begin
                     dir_up_d = go_above;
                  end
               end
            end
         end

         S_MOVE: begin
            if (!stop) begin
               if (move_cnt_q != MC_LAST) begin
                  move_cnt_d = move_cnt_q + 1'b1;
               end else begin
                  move_cnt_d = '0;
                  if ((dir_up_q && (floor_q == TOP_FLOOR)) ||
                      (!dir_up_q && (floor_q == '0))) begin
                     // Shaft end: turn around rather than step out of range
                     dir_up_d = !dir_up_q;
                  end else begin
                     step_floor = dir_up_q ? (floor_q + 1'b1) : (floor_q - 1'b1);
                     floor_d    = step_floor;
                     if (pend_eff[step_floor]) begin
                        state_d    = S_DOOR;
                        door_cnt_d = '0;
                     end else if (any_ahead(pend_eff, step_floor, dir_up_q)) begin
                        dir_up_d = dir_up_q;
                     end else if (any_ahead(pend_eff, step_floor, !dir_up_q)) begin
                        dir_up_d = !dir_up_q;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end
               end
            end
         end

         S_DOOR: begin
            // A call at this floor holds the door; stop only freezes the countdown
            if (req[floor_q]) begin
               door_cnt_d = '0;
            end else if (!stop) begin
               if (door_cnt_q == DC_LAST) begin
                  state_d    = S_IDLE;
                  door_cnt_d = '0;
               end else begin
                  door_cnt_d = door_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      arrived_d = (state_d == S_DOOR) && (state_q != S_DOOR);
   end

   // FSM, floor, heading and timer registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         floor_q    <= '0;
         dir_up_q   <= 1'b1;
         move_cnt_q <= '0;
         door_cnt_q <= '0;
         arrived_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         floor_q    <= floor_d;
         dir_up_q   <= dir_up_d;
         move_cnt_q <= move_cnt_d;
         door_cnt_q <= door_cnt_d;
         arrived_q  <= arrived_d;
      end
   end

`ifdef ELEVATOR_IDLE_HOME_EN
   localparam int ICW = $clog2(IDLE_CYCLES) + 1;
   localparam logic [ICW-1:0] IC_LAST = ICW'(IDLE_CYCLES - 1);

   logic [ICW-1:0] idle_cnt_q, idle_cnt_d;

   // Count quiet IDLE cycles away from floor 0; on timeout post an internal call to floor 0
   always_comb begin
      idle_cnt_d = '0;
      home_set   = 1'b0;
      if (state_q == S_IDLE) begin
         if (stop) begin
            idle_cnt_d = idle_cnt_q;
         end else if ((req != '0) || (pending != '0) || (floor_q == '0)) begin
            idle_cnt_d = '0;
         end else if (idle_cnt_q == IC_LAST) begin
            home_set = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
   end

   // Idle timeout register
   always_ff @(posedge clock) begin
      if (reset) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   localparam int unused_idle_cycles = IDLE_CYCLES;
   assign home_set = 1'b0;
`endif

   assign floor     = floor_q;
   assign dir_up    = dir_up_q;
   assign moving    = (state_q == S_MOVE);
   assign door_open = (state_q == S_DOOR);
   assign arrived   = arrived_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - directed and randomized check of elevator_ctrl against a behavioural car model
module tb_elevator_ctrl;

   localparam int NF = 8;
   localparam int MC = 2;
   localparam int DC = 4;
   localparam int IC = 16;
   localparam int FW = $clog2(NF);

   localparam int CAR_WAIT   = 0;
   localparam int CAR_TRAVEL = 1;
   localparam int CAR_OPEN   = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          stop;
   logic [NF-1:0] req;
   logic [FW-1:0] floor;
   logic [NF-1:0] pending;
   logic          dir_up;
   logic          moving;
   logic          door_open;
   logic          arrived;

   int total = 0;
   int bad   = 0;

   // Behavioural model of the car
   int      m_mode;
   int      m_floor;
   int      m_step_left;
   int      m_door_left;
   int      m_idle_run;
   bit      m_up;
   bit      m_arr;
   bit [NF-1:0] m_pend;
   bit      m_valid = 1'b0;

   int arr_q[$];
   int n;

   elevator_ctrl #(
      .NUM_FLOORS (NF),
      .MOVE_CYCLES(MC),
      .DOOR_CYCLES(DC),
      .IDLE_CYCLES(IC)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .stop     (stop),
      .req      (req),
      .floor    (floor),
      .pending  (pending),
      .dir_up   (dir_up),
      .moving   (moving),
      .door_open(door_open),
      .arrived  (arrived)
   );

   always #5 clock = ~clock;

   function automatic bit any_way(input bit [NF-1:0] p, input int f, input bit up);
      any_way = 1'b0;
      for (int i = 0; i < NF; i++) begin
         if (p[i] && (up ? (i > f) : (i < f))) any_way = 1'b1;
      end
   endfunction

   task automatic model_reset();
      m_mode      = CAR_WAIT;
      m_floor     = 0;
      m_up        = 1'b1;
      m_pend      = '0;
      m_arr       = 1'b0;
      m_step_left = MC;
      m_door_left = DC;
      m_idle_run  = 0;
   endtask

   task automatic model_tick(input bit [NF-1:0] r, input bit s);
      bit [NF-1:0] want;
      bit [NF-1:0] np;
      int of;
      int old_mode;
      bit arr;
      bit home;
      want     = m_pend | r;
      of       = m_floor;
      old_mode = m_mode;
      arr      = 1'b0;
      home     = 1'b0;
      if (m_mode == CAR_WAIT) begin
         if (!s) begin
            if (want[of]) begin
               m_mode = CAR_OPEN; m_door_left = DC; arr = 1'b1;
            end else if (any_way(want, of, 1'b1) || any_way(want, of, 1'b0)) begin
               if (!(any_way(want, of, 1'b1) && any_way(want, of, 1'b0)))
                  m_up = any_way(want, of, 1'b1);
               m_mode = CAR_TRAVEL; m_step_left = MC;
            end
         end
      end else if (m_mode == CAR_TRAVEL) begin
         if (!s) begin
            m_step_left--;
            if (m_step_left == 0) begin
               m_step_left = MC;
               if ((m_up && of == NF - 1) || (!m_up && of == 0)) begin
                  m_up = !m_up;
               end else begin
                  m_floor = m_up ? of + 1 : of - 1;
                  if (want[m_floor]) begin
                     m_mode = CAR_OPEN; m_door_left = DC; arr = 1'b1;
                  end else if (any_way(want, m_floor, m_up)) begin
                     m_up = m_up;
                  end else if (any_way(want, m_floor, !m_up)) begin
                     m_up = !m_up;
                  end else begin
                     m_mode = CAR_WAIT;
                  end
               end
            end
         end
      end else begin
         if (r[of]) m_door_left = DC;
         else if (!s) begin
            m_door_left--;
            if (m_door_left == 0) m_mode = CAR_WAIT;
         end
      end
`ifdef ELEVATOR_IDLE_HOME_EN
      if (old_mode == CAR_WAIT) begin
         if (!s) begin
            if (r != '0 || m_pend != '0 || of == 0) m_idle_run = 0;
            else begin
               m_idle_run++;
               if (m_idle_run == IC) begin home = 1'b1; m_idle_run = 0; end
            end
         end
      end else begin
         m_idle_run = 0;
      end
`endif
      np = m_pend | r;
      if (old_mode == CAR_OPEN) np[of] = m_pend[of];
      if (home) np[0] = 1'b1;
      if (arr) np[m_floor] = 1'b0;
      m_pend = np;
      m_arr  = arr;
   endtask

   // Advance the model on every rising edge with the inputs the DUT sees
   always @(posedge clock) begin
      if (reset) begin
         m_valid = 1'b1;
         model_reset();
      end else if (m_valid) begin
         model_tick(req, stop);
      end
   end

   // Cycle-by-cycle comparison on the falling edge
   always @(negedge clock) begin
      if (m_valid) begin
         total++;
         if (floor !== FW'(m_floor) || pending !== m_pend || dir_up !== m_up ||
             moving !== (m_mode == CAR_TRAVEL) || door_open !== (m_mode == CAR_OPEN) ||
             arrived !== m_arr) begin
            bad++;
            $display("FAIL cycle_check t=%0t dut: floor=%0d pend=%b up=%b mv=%b door=%b arr=%b model: floor=%0d pend=%b up=%b mv=%0d door=%0d arr=%b",
                     $time, floor, pending, dir_up, moving, door_open, arrived,
                     m_floor, m_pend, m_up, (m_mode == CAR_TRAVEL), (m_mode == CAR_OPEN), m_arr);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stop = 1'b0; req = '0;
      cyc();
      reset = 1'b0;
   endtask

   task automatic wait_floor(input int f, input int limit, input string name);
      int k;
      k = 0;
      while (int'(floor) != f && k < limit) begin
         cyc();
         k++;
      end
      check(name, 32'(floor), 32'(f));
   endtask

   task automatic wait_arrival(input int limit, input string name);
      int k;
      k = 0;
      while (arrived !== 1'b1 && k < limit) begin
         cyc();
         k++;
      end
      check(name, 32'(arrived), 32'd1);
   endtask

   initial begin
      reset = 1'b1; stop = 1'b0; req = '0;
      cyc();
      cyc();
      reset = 1'b0;

      // Reset state
      check("rst_floor", 32'(floor), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_dir_up", 32'(dir_up), 1);
      check("rst_moving", 32'(moving), 0);
      check("rst_door", 32'(door_open), 0);
      check("rst_arrived", 32'(arrived), 0);

      // Call to floor 5 from floor 0: move next cycle, 10 move cycles, 4 door cycles
      req = 8'b0010_0000;
      cyc();
      req = '0;
      check("a_moving", 32'(moving), 1);
      check("a_floor0", 32'(floor), 0);
      repeat (10) cyc();
      check("a_floor5", 32'(floor), 5);
      check("a_model_floor5", 32'(m_floor), 5);
      check("a_arrived", 32'(arrived), 1);
      check("a_door", 32'(door_open), 1);
      check("a_pending", 32'(pending), 0);
      n = 1;
      for (int k = 0; k < 12; k++) begin
         cyc();
         if (door_open) n++;
         else break;
      end
      check("a_door_cycles", 32'(n), 4);

      // Moving up at floor 3 with calls at 1 and 6: serve 6 then 1
      do_reset();
      req = 8'b0100_0000;
      cyc();
      req = '0;
      wait_floor(3, 40, "b_reach3");
      req = 8'b0000_0010;
      cyc();
      req = '0;
      check("b_pending", 32'(pending), 32'b0100_0010);
      check("b_dir_up", 32'(dir_up), 1);
      arr_q.delete();
      for (int k = 0; k < 200 && arr_q.size() < 2; k++) begin
         cyc();
         if (arrived) arr_q.push_back(int'(floor));
      end
      check("b_arrivals", 32'(arr_q.size()), 2);
      if (arr_q.size() >= 2) begin
         check("b_first", 32'(arr_q[0]), 6);
         check("b_second", 32'(arr_q[1]), 1);
      end

      // Stop for 5 cycles just after reaching floor 2; a call during stop is latched
      do_reset();
      req = 8'b1000_0000;
      cyc();
      req = '0;
      wait_floor(2, 40, "c_reach2");
      stop = 1'b1;
      req  = 8'b0000_0100;
      cyc();
      req = '0;
      repeat (4) cyc();
      check("c_frozen_floor", 32'(floor), 2);
      check("c_frozen_moving", 32'(moving), 1);
      check("c_latched", 32'(pending), 32'b1000_0100);
      stop = 1'b0;
      cyc();
      check("c_resume1", 32'(floor), 2);
      cyc();
      check("c_resume2", 32'(floor), 3);

      // Call for the floor with the door open restarts the door timer
      wait_arrival(60, "d_arrive");
      check("d_floor7", 32'(floor), 7);
      cyc();
      cyc();
      req = 8'b1000_0000;
      cyc();
      req = '0;
      check("d_not_latched", 32'(pending[7]), 0);
      check("d_door_held", 32'(door_open), 1);
      n = 1;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (door_open) n++;
         else break;
      end
      check("d_door_after_restart", 32'(n), 4);

      // Reset in the middle of a move
      do_reset();
      req = 8'b0100_0000;
      cyc();
      req = '0;
      wait_floor(4, 40, "e_reach4");
      cyc();
      check("e_midmove", 32'(moving), 1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("e_floor", 32'(floor), 0);
      check("e_moving", 32'(moving), 0);
      check("e_door", 32'(door_open), 0);
      check("e_pending", 32'(pending), 0);
      check("e_dir_up", 32'(dir_up), 1);

`ifdef ELEVATOR_IDLE_HOME_EN
      // Idle away from floor 0 long enough and the car goes home
      do_reset();
      req = 8'b0000_1000;
      cyc();
      req = '0;
      wait_arrival(40, "f_arrive3");
      n = 0;
      while (door_open && n < 20) begin
         cyc();
         n++;
      end
      check("f_door_closed", 32'(door_open), 0);
      n = 0;
      while (pending[0] !== 1'b1 && n < 40) begin
         cyc();
         n++;
      end
      check("f_idle_cycles", 32'(n), 16);
      wait_arrival(40, "f_arrive0");
      check("f_floor0", 32'(floor), 0);
      check("f_door0", 32'(door_open), 1);
`endif

      // Randomized traffic with occasional stop and reset
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         int r;
         reset = ($urandom_range(0, 799) == 0);
         stop  = ($urandom_range(0, 9) == 0);
         req   = '0;
         r     = $urandom_range(0, 15);
         if (r == 0) req = NF'($urandom);
         else if (r < 3) req[$urandom_range(0, NF - 1)] = 1'b1;
         cyc();
      end
      reset = 1'b0; stop = 1'b0; req = '0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
